// File: rtl/scarv_cop_palu_seq.sv
// Issue/writeback sequencer around the SCARV packed ALU: latches one decoded
// instruction, feeds CPR operands to the PALU, commits its byte-enabled result.
// Optional EXEC watchdog enabled by defining SCARV_COP_PALU_SEQ_TIMEOUT_EN.
module scarv_cop_palu_seq #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [3:0]  dec_crs1,
  input  logic [3:0]  dec_crs2,
  input  logic [3:0]  dec_crs3,
  input  logic [3:0]  dec_crd,
  input  logic [31:0] dec_gpr_rs1,
  input  logic [31:0] dec_imm,
  input  logic [2:0]  dec_pw,
  input  logic [3:0]  dec_class,
  input  logic [4:0]  dec_subclass,
  output logic        palu_ivalid,
  output logic [31:0] gpr_rs1,
  output logic [31:0] palu_rs1,
  output logic [31:0] palu_rs2,
  output logic [31:0] palu_rs3,
  output logic [31:0] id_imm,
  output logic [2:0]  id_pw,
  output logic [3:0]  id_class,
  output logic [4:0]  id_subclass,
  input  logic        palu_idone,
  input  logic [3:0]  palu_cpr_rd_ben,
  input  logic [31:0] palu_cpr_rd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wen,
  output logic        rsp_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] cpr_reg [16];
  logic [3:0]  crs1_reg, crs2_reg, crs3_reg, crd_reg;
  logic [31:0] gpr_reg, imm_reg;
  logic [2:0]  pw_reg;
  logic [3:0]  class_reg;
  logic [4:0]  subclass_reg;
  logic        rsp_wen_reg;
  logic        accept, commit, rsp_done, timeout_hit;
  logic [31:0] wr_word;

  assign accept   = (state_reg == IDLE) && dec_valid;
  assign commit   = (state_reg == EXEC) && palu_idone;
  assign rsp_done = (state_reg == RESP) && rsp_ready;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    dec_ready   = 1'b0;
    palu_ivalid = 1'b0;
    rsp_valid   = 1'b0;
    case (state_reg)
      IDLE: begin
        dec_ready = 1'b1;
        if (dec_valid) state_next = EXEC;
      end
      EXEC: begin
        palu_ivalid = 1'b1;
        if (palu_idone || timeout_hit) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      crs1_reg     <= '0;
      crs2_reg     <= '0;
      crs3_reg     <= '0;
      crd_reg      <= '0;
      gpr_reg      <= '0;
      imm_reg      <= '0;
      pw_reg       <= '0;
      class_reg    <= '0;
      subclass_reg <= '0;
    end else if (accept) begin
      crs1_reg     <= dec_crs1;
      crs2_reg     <= dec_crs2;
      crs3_reg     <= dec_crs3;
      crd_reg      <= dec_crd;
      gpr_reg      <= dec_gpr_rs1;
      imm_reg      <= dec_imm;
      pw_reg       <= dec_pw;
      class_reg    <= dec_class;
      subclass_reg <= dec_subclass;
    end
  end

  // Merge enabled PALU bytes over the current destination word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_merge
      assign wr_word[8*gi +: 8] = palu_cpr_rd_ben[gi] ? palu_cpr_rd_wdata[8*gi +: 8]
                                                      : cpr_reg[crd_reg][8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      for (int i = 0; i < 16; i++) cpr_reg[i] <= '0;
    end else if (commit) begin
      cpr_reg[crd_reg] <= wr_word;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset)       rsp_wen_reg <= 1'b0;
    else if (commit)   rsp_wen_reg <= |palu_cpr_rd_ben;
    else if (rsp_done) rsp_wen_reg <= 1'b0;
  end

`ifdef SCARV_COP_PALU_SEQ_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt_reg;
  logic       rsp_error_reg;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset)                                   tmo_cnt_reg <= '0;
    else if (accept)                               tmo_cnt_reg <= '0;
    else if ((state_reg == EXEC) && !palu_idone)   tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
  end

  // A completion arriving on the final cycle takes priority over the abort.
  assign timeout_hit = (state_reg == EXEC) && !palu_idone && (tmo_cnt_reg == TMO_LAST);

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset)          rsp_error_reg <= 1'b0;
    else if (timeout_hit) rsp_error_reg <= 1'b1;
    else if (rsp_done)    rsp_error_reg <= 1'b0;
  end

  assign rsp_error = rsp_error_reg;
`else
  assign timeout_hit = 1'b0;
  assign rsp_error   = 1'b0;
`endif

  assign gpr_rs1     = gpr_reg;
  assign palu_rs1    = cpr_reg[crs1_reg];
  assign palu_rs2    = cpr_reg[crs2_reg];
  assign palu_rs3    = cpr_reg[crs3_reg];
  assign id_imm      = imm_reg;
  assign id_pw       = pw_reg;
  assign id_class    = class_reg;
  assign id_subclass = subclass_reg;
  assign rsp_wen     = rsp_wen_reg;

endmodule

// File: tb/tb_scarv_cop_palu_seq.sv
// Directed bench for scarv_cop_palu_seq: a CPR array model plus per-cycle
// expected handshake values, compared on every falling clock edge.
module tb_scarv_cop_palu_seq;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        dec_valid = 1'b0;
  logic        dec_ready;
  logic [3:0]  dec_crs1 = '0, dec_crs2 = '0, dec_crs3 = '0, dec_crd = '0;
  logic [31:0] dec_gpr_rs1 = '0, dec_imm = '0;
  logic [2:0]  dec_pw = '0;
  logic [3:0]  dec_class = '0;
  logic [4:0]  dec_subclass = '0;
  logic        palu_ivalid;
  logic [31:0] gpr_rs1, palu_rs1, palu_rs2, palu_rs3, id_imm;
  logic [2:0]  id_pw;
  logic [3:0]  id_class;
  logic [4:0]  id_subclass;
  logic        palu_idone = 1'b0;
  logic [3:0]  palu_cpr_rd_ben = '0;
  logic [31:0] palu_cpr_rd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_wen;
  logic        rsp_error;

  scarv_cop_palu_seq #(.TIMEOUT_CYCLES(8)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_crs1(dec_crs1), .dec_crs2(dec_crs2), .dec_crs3(dec_crs3), .dec_crd(dec_crd),
    .dec_gpr_rs1(dec_gpr_rs1), .dec_imm(dec_imm), .dec_pw(dec_pw),
    .dec_class(dec_class), .dec_subclass(dec_subclass),
    .palu_ivalid(palu_ivalid), .gpr_rs1(gpr_rs1),
    .palu_rs1(palu_rs1), .palu_rs2(palu_rs2), .palu_rs3(palu_rs3),
    .id_imm(id_imm), .id_pw(id_pw), .id_class(id_class), .id_subclass(id_subclass),
    .palu_idone(palu_idone), .palu_cpr_rd_ben(palu_cpr_rd_ben),
    .palu_cpr_rd_wdata(palu_cpr_rd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wen(rsp_wen), .rsp_error(rsp_error)
  );

  always #5 g_clk = ~g_clk;

  // Model state: CPR contents, latched instruction fields, expected handshakes.
  logic [31:0] cpr_m [16];
  logic [3:0]  lat_s1, lat_s2, lat_s3;
  logic [31:0] lat_gpr, lat_imm;
  logic [2:0]  lat_pw;
  logic [3:0]  lat_cls;
  logic [4:0]  lat_sub;
  logic        exp_ready, exp_ivalid, exp_rvalid, exp_wen, exp_err;
  bit          chk_en = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge g_clk) begin
    if (chk_en) begin
      chk("dec_ready",   32'(dec_ready),   32'(exp_ready));
      chk("palu_ivalid", 32'(palu_ivalid), 32'(exp_ivalid));
      chk("rsp_valid",   32'(rsp_valid),   32'(exp_rvalid));
      chk("rsp_wen",     32'(rsp_wen),     32'(exp_wen));
      chk("rsp_error",   32'(rsp_error),   32'(exp_err));
      chk("palu_rs1",    palu_rs1,         cpr_m[lat_s1]);
      chk("palu_rs2",    palu_rs2,         cpr_m[lat_s2]);
      chk("palu_rs3",    palu_rs3,         cpr_m[lat_s3]);
      chk("gpr_rs1",     gpr_rs1,          lat_gpr);
      chk("id_imm",      id_imm,           lat_imm);
      chk("id_pw",       32'(id_pw),       32'(lat_pw));
      chk("id_class",    32'(id_class),    32'(lat_cls));
      chk("id_subclass", 32'(id_subclass), 32'(lat_sub));
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) cpr_m[i] = '0;
    lat_s1 = '0; lat_s2 = '0; lat_s3 = '0;
    lat_gpr = '0; lat_imm = '0; lat_pw = '0; lat_cls = '0; lat_sub = '0;
    exp_ready = 1'b1; exp_ivalid = 1'b0; exp_rvalid = 1'b0; exp_wen = 1'b0; exp_err = 1'b0;
  endtask

  // Idle cycles with a stray palu_idone, which must not touch the CPRs.
  task automatic idle(input int n);
    palu_idone = 1'b1; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'hBADBAD00;
    repeat (n) begin @(posedge g_clk); #1; end
    palu_idone = 1'b0;
  endtask

  // One instruction: accept cycle, exec_n EXEC cycles, stall+1 RESP cycles.
  task automatic issue(input logic [3:0] s1, s2, s3, d,
                       input logic [31:0] gpr, imm, input logic [2:0] pw,
                       input logic [3:0] cls, input logic [4:0] sub,
                       input int exec_n, input bit done, input logic [3:0] ben,
                       input logic [31:0] wd, input int stall, input bit noise);
    dec_valid = 1'b1; dec_crs1 = s1; dec_crs2 = s2; dec_crs3 = s3; dec_crd = d;
    dec_gpr_rs1 = gpr; dec_imm = imm; dec_pw = pw; dec_class = cls; dec_subclass = sub;
    @(posedge g_clk); #1;
    dec_valid = 1'b0;
    lat_s1 = s1; lat_s2 = s2; lat_s3 = s3; lat_gpr = gpr; lat_imm = imm;
    lat_pw = pw; lat_cls = cls; lat_sub = sub;
    exp_ready = 1'b0; exp_ivalid = 1'b1;
    for (int k = 0; k < exec_n; k++) begin
      palu_idone = done && (k == exec_n - 1);
      palu_cpr_rd_ben = ben; palu_cpr_rd_wdata = wd;
      if (noise) begin
        dec_valid = 1'b1; dec_crs1 = 4'($urandom); dec_crs2 = 4'($urandom);
        dec_crs3 = 4'($urandom); dec_crd = 4'($urandom);
        dec_gpr_rs1 = $urandom; dec_imm = $urandom; dec_pw = 3'($urandom);
        dec_class = 4'($urandom); dec_subclass = 5'($urandom);
      end
      @(posedge g_clk); #1;
    end
    palu_idone = 1'b0; dec_valid = 1'b0;
    if (done) begin
      for (int b = 0; b < 4; b++)
        if (ben[b]) cpr_m[d][8*b +: 8] = wd[8*b +: 8];
      exp_wen = |ben; exp_err = 1'b0;
    end else begin
      exp_wen = 1'b0; exp_err = 1'b1;
    end
    exp_ivalid = 1'b0; exp_rvalid = 1'b1;
    for (int s = 0; s <= stall; s++) begin
      rsp_ready = (s == stall);
      if (noise) begin
        dec_valid = 1'b1; dec_imm = $urandom;
        palu_idone = 1'b1; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = $urandom;
      end
      @(posedge g_clk); #1;
    end
    rsp_ready = 1'b0; palu_idone = 1'b0; dec_valid = 1'b0;
    exp_ready = 1'b1; exp_rvalid = 1'b0; exp_wen = 1'b0; exp_err = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge g_clk);
    #1;
    chk("rst_dec_ready",   32'(dec_ready),   32'd1);
    chk("rst_palu_ivalid", 32'(palu_ivalid), 32'd0);
    chk("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    chk("rst_rsp_wen",     32'(rsp_wen),     32'd0);
    chk("rst_id_imm",      id_imm,           32'd0);
    g_reset = 1'b0;
    chk_en = 1'b1;
    idle(1);

    // Full write, single-cycle PALU.
    issue(4'd3, 4'd0, 4'd1, 4'd3, 32'h0BADF00D, 32'h00000042, 3'd2, 4'h5, 5'h11,
          1, 1'b1, 4'hF, 32'h12345678, 0, 1'b0);
    chk("model_cpr3_full", cpr_m[3], 32'h12345678);
    // Partial write with crd == crs1 (operand is the pre-commit value).
    issue(4'd3, 4'd3, 4'd3, 4'd3, 32'h1, 32'h2, 3'd1, 4'h2, 5'h03,
          1, 1'b1, 4'h3, 32'hAABBCCDD, 0, 1'b0);
    chk("model_cpr3_part", cpr_m[3], 32'h1234CCDD);
    // No byte enables: no change, rsp_wen low.
    issue(4'd3, 4'd2, 4'd1, 4'd3, 32'h3, 32'h4, 3'd0, 4'h1, 5'h01,
          1, 1'b1, 4'h0, 32'hFFFFFFFF, 0, 1'b0);
    chk("model_cpr3_ben0", cpr_m[3], 32'h1234CCDD);
    issue(4'd0, 4'd0, 4'd0, 4'd1, 32'h0, 32'h0, 3'd0, 4'h0, 5'h00,
          1, 1'b1, 4'hF, 32'h11112222, 0, 1'b0);
    issue(4'd0, 4'd0, 4'd0, 4'd2, 32'h0, 32'h0, 3'd0, 4'h0, 5'h00,
          1, 1'b1, 4'hC, 32'h3333ABCD, 0, 1'b0);
    chk("model_cpr2_hi", cpr_m[2], 32'h33330000);
    idle(2);
    // Multi-cycle PALU with decoder noise during EXEC/RESP.
    issue(4'd3, 4'd1, 4'd2, 4'd7, 32'hCAFE0001, 32'hFEED0002, 3'd4, 4'h9, 5'h1F,
          5, 1'b1, 4'hF, 32'h77777777, 0, 1'b1);
    // Response backpressure for three cycles.
    issue(4'd7, 4'd3, 4'd1, 4'd8, 32'h01020304, 32'h05060708, 3'd3, 4'hA, 5'h0A,
          2, 1'b1, 4'h6, 32'h00ABCD00, 3, 1'b1);
    chk("model_cpr8", cpr_m[8], 32'h00ABCD00);
    idle(1);
`ifdef SCARV_COP_PALU_SEQ_TIMEOUT_EN
    issue(4'd8, 4'd7, 4'd3, 4'd8, 32'h0, 32'h0, 3'd0, 4'h0, 5'h00,
          8, 1'b0, 4'hF, 32'hDEADBEEF, 1, 1'b0);
    chk("model_cpr8_tmo", cpr_m[8], 32'h00ABCD00);
    issue(4'd8, 4'd7, 4'd3, 4'd9, 32'h0, 32'h0, 3'd0, 4'h0, 5'h00,
          8, 1'b1, 4'hF, 32'h99990000, 0, 1'b0);
`else
    issue(4'd8, 4'd7, 4'd3, 4'd9, 32'h0, 32'h0, 3'd0, 4'h0, 5'h00,
          101, 1'b1, 4'hF, 32'h99990000, 0, 1'b0);
`endif
    // Reset in the middle of EXEC with a completion pending.
    issue(4'd0, 4'd0, 4'd0, 4'd5, 32'h0, 32'h0, 3'd0, 4'h0, 5'h00,
          1, 1'b1, 4'hF, 32'hCAFEF00D, 0, 1'b0);
    dec_valid = 1'b1; dec_crs1 = 4'd5; dec_crs2 = 4'd9; dec_crs3 = 4'd8; dec_crd = 4'd5;
    dec_imm = 32'h5A5A5A5A;
    @(posedge g_clk); #1;
    dec_valid = 1'b0;
    lat_s1 = 4'd5; lat_s2 = 4'd9; lat_s3 = 4'd8; lat_imm = 32'h5A5A5A5A;
    lat_gpr = dec_gpr_rs1; lat_pw = dec_pw; lat_cls = dec_class; lat_sub = dec_subclass;
    exp_ready = 1'b0; exp_ivalid = 1'b1;
    @(negedge g_clk); #1;
    chk_en = 1'b0;
    chk("pre_rst_rs1", palu_rs1, 32'hCAFEF00D);
    palu_idone = 1'b1; palu_cpr_rd_ben = 4'hF; palu_cpr_rd_wdata = 32'h0F0F0F0F;
    #1 g_reset = 1'b1;
    #1;
    chk("mid_rst_ivalid",    32'(palu_ivalid), 32'd0);
    chk("mid_rst_dec_ready", 32'(dec_ready),   32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid),   32'd0);
    chk("mid_rst_rs1",       palu_rs1,         32'd0);
    @(posedge g_clk); #1;
    palu_idone = 1'b0;
    g_reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    for (int i = 0; i < 16; i++)
      issue(4'(i), 4'(15 - i), 4'(i), 4'(i), 32'(i), 32'(i * 3), 3'(i), 4'(i), 5'(i),
            1, 1'b1, 4'h0, 32'hFFFFFFFF, 0, 1'b0);
    idle(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scarv_cop_palu_seq.md
Name: scarv_cop_palu_seq

Overview:
Issue/writeback sequencer directly upstream and downstream of the packed-ALU datapath in the SCARV coprocessor.
- Accepts one decoded coprocessor instruction from the decoder.
- Reads its operands from an internal 16 x 32-bit CPR register file and presents them to the PALU.
- Holds the instruction until the PALU signals done, then commits the byte-enabled result to the CPR file and returns a completion response to the CPU side.
- One instruction in flight at a time.

Parameters:
TIMEOUT_CYCLES, 64, maximum EXEC cycles before abort (used only with the optional feature; legal range 2..255).

Ports:
g_clk  in  1  global clock
g_reset  in  1  asynchronous active-high reset
dec_valid  in  1  decoded instruction valid
dec_ready  out  1  sequencer can accept an instruction
dec_crs1 / dec_crs2 / dec_crs3 / dec_crd  in  4 each  CPR source and destination indexes
dec_gpr_rs1  in  32  GPR source value
dec_imm  in  32  immediate
dec_pw  in  3  pack width
dec_class  in  4  instruction class
dec_subclass  in  5  instruction subclass
palu_ivalid  out  1  instruction valid to PALU
gpr_rs1  out  32  latched GPR value
palu_rs1 / palu_rs2 / palu_rs3  out  32 each  CPR operands
id_imm  out  32  latched immediate
id_pw  out  3  latched pack width
id_class  out  4  latched class
id_subclass  out  5  latched subclass
palu_idone  in  1  PALU instruction complete
palu_cpr_rd_ben  in  4  PALU writeback byte enables
palu_cpr_rd_wdata  in  32  PALU writeback data
rsp_valid  out  1  completion response valid
rsp_ready  in  1  response accepted
rsp_wen  out  1  at least one CPR byte was written
rsp_error  out  1  instruction aborted (optional feature only)

Behaviour:
- Reset (asynchronous, g_reset=1):
  - state=IDLE; all 16 CPRs=0; all latched fields=0; timeout counter=0.
  - Outputs during/after reset: dec_ready=1, palu_ivalid=0, rsp_valid=0, rsp_wen=0, rsp_error=0.
  - All other outputs reflect zeroed latches.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - dec_ready=1.
  - On dec_valid: latch all dec_* fields; -> EXEC next cycle.
- EXEC:
  - palu_ivalid=1; dec_ready=0.
  - palu_rs1/2/3 = cpr[crs1/2/3] read combinationally from latched indexes; all operands stable for the whole state.
  - On the clock edge with palu_idone=1:
    - for each byte i with ben[i]=1: cpr[crd][8i+7:8i] <= wdata[8i+7:8i];
    - latch rsp_wen = |ben;
    - -> RESP.
  - palu_idone=0: remain in EXEC indefinitely.
- RESP:
  - rsp_valid=1; dec_ready=0; palu_ivalid=0.
  - On rsp_ready: -> IDLE; rsp_wen and rsp_error cleared.
- Latency: accept edge -> palu_ivalid high next cycle. Single-cycle PALU gives rsp_valid 2 cycles after accept.
- Throughput: with rsp_ready=1 and a single-cycle PALU, one instruction every 3 cycles.
- Write to crd is visible to the next instruction's operand read; no bypass is needed since no overlap exists.
- crd equal to a crs index: operands are read before commit; the new value appears only after the commit edge.
- palu_idone outside EXEC is ignored. ben=0 in EXEC: no CPR change, rsp_wen=0.
- dec_valid during EXEC/RESP is ignored (not latched).
- Reset mid-EXEC or mid-RESP: immediate return to IDLE; palu_ivalid/rsp_valid drop asynchronously; no partial CPR write.

Optional Feature:
SCARV_COP_PALU_SEQ_TIMEOUT_EN
- Defined:
  - 8-bit counter cleared on entry to EXEC, incremented each EXEC cycle without palu_idone.
  - If counter==TIMEOUT_CYCLES-1 and palu_idone=0: no CPR write; -> RESP with rsp_error=1, rsp_wen=0.
  - palu_idone on that same edge wins: normal commit, rsp_error=0.
- Undefined: no counter logic; rsp_error tied 0; EXEC waits indefinitely.

Test Plan:
1. Reset: assert g_reset mid-run -> dec_ready=1, palu_ivalid=0, rsp_valid=0. Read cpr[0..15] via issued moves -> all 0x00000000.
2. Full write with single-cycle PALU model: crd=3, idone returned with ben=0xF, wdata=0x12345678 -> cpr[3]=0x12345678; rsp_valid 2 cycles after accept; rsp_wen=1.
3. Partial write: cpr[3]=0x12345678, then ben=0x3, wdata=0xAABBCCDD -> cpr[3]=0x1234CCDD; ben=0x0 -> unchanged, rsp_wen=0.
4. Multi-cycle PALU: idone delayed 4 cycles -> palu_ivalid high exactly 5 cycles; palu_rs1..3 and id_* constant; dec_valid pulses during EXEC are ignored.
5. Backpressure: rsp_ready low 3 cycles -> rsp_valid held with rsp_wen stable, dec_ready=0; IDLE one cycle after rsp_ready=1.
6. Timeout (macro defined, TIMEOUT_CYCLES=8): idone never asserted -> RESP after 8 EXEC cycles with rsp_error=1 and no CPR change. Macro undefined -> still in EXEC after 100 cycles.
